// File: rtl/batalha_pkg.sv
// Shared types for the battleship memory clients: cell codes, row geometry and the
// shot-collider FSM encoding.
package batalha_pkg;

    localparam int unsigned ROW_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned COL_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PTS_W = 6;

    typedef enum logic [1:0] {
        AGUA   = 2'b00,
        NAVIO  = 2'b01,
        ERRO   = 2'b10,
        ACERTO = 2'b11
    } cell_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRead,
        StCheck,
        StWrite,
        StDone
    } colisor_state_e;

endpackage

// File: rtl/colisor_celula.sv
// Combinational cell accessor: extracts the 2-bit cell at a column of a board row and
// returns the row with only that cell replaced by a new code.
module colisor_celula
    import batalha_pkg::*;
(
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    input  cell_e            code_i,
    output cell_e            old_o,
    output logic [ROW_W-1:0] row_o
);

    logic [COL_W:0]   sh;
    logic [ROW_W-1:0] shifted;
    logic [ROW_W-1:0] mask;

    always_comb begin
        sh      = {col_i, 1'b0};
        shifted = row_i >> sh;
        old_o   = cell_e'(shifted[1:0]);
        mask    = ROW_W'(2'b11) << sh;
        row_o   = (row_i & ~mask) | (ROW_W'(code_i) << sh);
    end

endmodule

// File: rtl/colisor_tiro.sv
// Shot collider: requests the player-memory bus, reads a board row, classifies the target
// cell and writes back the marked row. Optional scoreboard under COLISOR_PLACAR_EN.
module colisor_tiro
    import batalha_pkg::*;
#(
    parameter int unsigned GRANT_LAT  = 2,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned SHIP_CELLS = 17
) (
    input  logic              clk,
    input  logic              resetGeral,
    input  logic              tiro_valido,
    input  logic              tiro_jogador,
    input  logic [ADDR_W-1:0] tiro_linha,
    input  logic [COL_W-1:0]  tiro_coluna,
    input  logic              readyValidador,
    input  logic [ROW_W-1:0]  dataReadColisor,
    output logic              readyColisor,
    output logic              jogadorColisor,
    output logic [ADDR_W-1:0] colisor_addr,
    output logic              colisor_wrep1,
    output logic              colisor_wrep2,
    output logic [ROW_W-1:0]  colisor_data,
    output logic              tiro_ocupado,
    output logic              resultado_valido,
    output logic              acerto,
    output logic              repetido
`ifdef COLISOR_PLACAR_EN
   ,output logic [PTS_W-1:0]  pontos_p1,
    output logic [PTS_W-1:0]  pontos_p2,
    output logic              fim_jogo
`endif
);

    colisor_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              jog_q, jog_d;
    logic [ADDR_W-1:0] linha_q, linha_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  data_q, data_d;
    logic              acerto_q, acerto_d;
    logic              rep_q, rep_d;

    cell_e             old_code;
    cell_e             new_code;
    logic [ROW_W-1:0]  row_upd;

    // Water becomes miss, ship becomes hit: low bit preserved, high bit set.
    assign new_code = old_code[0] ? ACERTO : ERRO;

    colisor_celula u_celula (
        .row_i  (dataReadColisor),
        .col_i  (col_q),
        .code_i (new_code),
        .old_o  (old_code),
        .row_o  (row_upd)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        jog_d    = jog_q;
        linha_d  = linha_q;
        col_d    = col_q;
        data_d   = data_q;
        acerto_d = acerto_q;
        rep_d    = rep_q;
        unique case (state_q)
            StIdle: begin
                if (tiro_valido) begin
                    jog_d   = tiro_jogador;
                    linha_d = tiro_linha;
                    col_d   = tiro_coluna;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Controller serves the validator first; our grant wait restarts.
                if (readyValidador) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(GRANT_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StRead;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRead: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                unique case (old_code)
                    AGUA, NAVIO: begin
                        rep_d    = 1'b0;
                        acerto_d = old_code[0];
                        data_d   = row_upd;
                        state_d  = StWrite;
                    end
                    default: begin
                        rep_d    = 1'b1;
                        acerto_d = 1'b0;
                        state_d  = StDone;
                    end
                endcase
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            jog_q    <= 1'b0;
            linha_q  <= '0;
            col_q    <= '0;
            data_q   <= '0;
            acerto_q <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            jog_q    <= jog_d;
            linha_q  <= linha_d;
            col_q    <= col_d;
            data_q   <= data_d;
            acerto_q <= acerto_d;
            rep_q    <= rep_d;
        end
    end

    // Outputs decode the state register so an async reset clears them at once.
    always_comb begin
        readyColisor     = state_q inside {StReq, StRead, StCheck, StWrite};
        jogadorColisor   = jog_q;
        colisor_addr     = linha_q;
        colisor_wrep1    = (state_q == StWrite) && !jog_q;
        colisor_wrep2    = (state_q == StWrite) && jog_q;
        colisor_data     = data_q;
        tiro_ocupado     = (state_q != StIdle);
        resultado_valido = (state_q == StDone);
        acerto           = acerto_q;
        repetido         = rep_q;
    end

`ifdef COLISOR_PLACAR_EN
    logic [PTS_W-1:0] p1_q, p1_d;
    logic [PTS_W-1:0] p2_q, p2_d;
    logic             fim_q, fim_d;

    always_comb begin
        p1_d = p1_q;
        p2_d = p2_q;
        if (state_q == StWrite && acerto_q) begin
            if (jog_q && p2_q != '1) begin
                p2_d = p2_q + 1'b1;
            end else if (!jog_q && p1_q != '1) begin
                p1_d = p1_q + 1'b1;
            end
        end
        fim_d = fim_q || (p1_d == PTS_W'(SHIP_CELLS)) || (p2_d == PTS_W'(SHIP_CELLS));
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            p1_q  <= '0;
            p2_q  <= '0;
            fim_q <= 1'b0;
        end else begin
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            fim_q <= fim_d;
        end
    end

    assign pontos_p1 = p1_q;
    assign pontos_p2 = p2_q;
    assign fim_jogo  = fim_q;
`endif

endmodule

// File: tb/tb_colisor_tiro.sv
// Directed bench for colisor_tiro with a two-board memory model standing in for the
// controller; scoreboard checks run only when COLISOR_PLACAR_EN is defined.
module tb_colisor_tiro;

    logic        clk = 1'b0;
    logic        resetGeral;
    logic        tiro_valido;
    logic        tiro_jogador;
    logic [4:0]  tiro_linha;
    logic [4:0]  tiro_coluna;
    logic        readyValidador;
    logic [63:0] dataReadColisor;
    logic        readyColisor;
    logic        jogadorColisor;
    logic [4:0]  colisor_addr;
    logic        colisor_wrep1;
    logic        colisor_wrep2;
    logic [63:0] colisor_data;
    logic        tiro_ocupado;
    logic        resultado_valido;
    logic        acerto;
    logic        repetido;
`ifdef COLISOR_PLACAR_EN
    logic [5:0]  pontos_p1;
    logic [5:0]  pontos_p2;
    logic        fim_jogo;
`endif

    logic [63:0] mem1 [32];
    logic [63:0] mem2 [32];
    logic        pl_en;
    logic        pl_sel;
    logic [4:0]  pl_addr;
    logic [63:0] pl_val;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    colisor_tiro #(
        .GRANT_LAT  (2),
        .READ_LAT   (2),
        .SHIP_CELLS (2)
    ) dut (
        .clk              (clk),
        .resetGeral       (resetGeral),
        .tiro_valido      (tiro_valido),
        .tiro_jogador     (tiro_jogador),
        .tiro_linha       (tiro_linha),
        .tiro_coluna      (tiro_coluna),
        .readyValidador   (readyValidador),
        .dataReadColisor  (dataReadColisor),
        .readyColisor     (readyColisor),
        .jogadorColisor   (jogadorColisor),
        .colisor_addr     (colisor_addr),
        .colisor_wrep1    (colisor_wrep1),
        .colisor_wrep2    (colisor_wrep2),
        .colisor_data     (colisor_data),
        .tiro_ocupado     (tiro_ocupado),
        .resultado_valido (resultado_valido),
        .acerto           (acerto),
        .repetido         (repetido)
`ifdef COLISOR_PLACAR_EN
       ,.pontos_p1        (pontos_p1),
        .pontos_p2        (pontos_p2),
        .fim_jogo         (fim_jogo)
`endif
    );

    assign dataReadColisor = jogadorColisor ? mem2[colisor_addr] : mem1[colisor_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_sel) mem2[pl_addr] <= pl_val;
            else        mem1[pl_addr] <= pl_val;
        end
        if (colisor_wrep1) mem1[colisor_addr] <= colisor_data;
        if (colisor_wrep2) mem2[colisor_addr] <= colisor_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [4:0] addr, input logic [63:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_sel  = sel;
        pl_addr = addr;
        pl_val  = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues a shot, scrambles the shot inputs and fires a stray request while busy,
    // holds readyValidador for `hold` cycles, and waits (bounded) for the result pulse.
    task automatic run_shot(input logic jog, input logic [4:0] lin, input logic [4:0] col,
                            input int hold, output int lat, output int wr1, output int wr2);
        @(negedge clk);
        tiro_jogador   = jog;
        tiro_linha     = lin;
        tiro_coluna    = col;
        tiro_valido    = 1'b1;
        readyValidador = (hold > 0);
        lat = 0;
        wr1 = 0;
        wr2 = 0;
        do begin
            @(negedge clk);
            lat++;
            if (colisor_wrep1) wr1++;
            if (colisor_wrep2) wr2++;
            tiro_valido  = (lat == 3);
            tiro_jogador = ~jog;
            tiro_linha   = lin ^ 5'h15;
            tiro_coluna  = col ^ 5'h0a;
            if (lat > hold) readyValidador = 1'b0;
        end while (!resultado_valido && lat < 40);
        tiro_valido = 1'b0;
        check_eq("result_seen", 64'(resultado_valido), 64'd1);
    endtask

    int lat, wr1, wr2, n;
    logic seen;

    initial begin
        resetGeral     = 1'b0;
        tiro_valido    = 1'b0;
        tiro_jogador   = 1'b0;
        tiro_linha     = '0;
        tiro_coluna    = '0;
        readyValidador = 1'b0;
        pl_en          = 1'b0;
        pl_sel         = 1'b0;
        pl_addr        = '0;
        pl_val         = '0;

        for (int i = 0; i < 32; i++) begin
            preload(1'b0, 5'(i), 64'd0);
            preload(1'b1, 5'(i), 64'd0);
        end

        check_eq("rst_ready", 64'(readyColisor), 64'd0);
        check_eq("rst_busy", 64'(tiro_ocupado), 64'd0);
        check_eq("rst_wren", 64'({colisor_wrep1, colisor_wrep2}), 64'd0);
        check_eq("rst_res", 64'({resultado_valido, acerto, repetido}), 64'd0);
        check_eq("rst_data", colisor_data, 64'd0);
        check_eq("rst_addr", 64'({jogadorColisor, colisor_addr}), 64'd0);

        @(negedge clk);
        resetGeral = 1'b1;

        // 1: water on P1 row 3, column 7
        run_shot(1'b0, 5'd3, 5'd7, 0, lat, wr1, wr2);
        check_eq("t1_lat", 64'(lat), 64'd7);
        check_eq("t1_wr1", 64'(wr1), 64'd1);
        check_eq("t1_wr2", 64'(wr2), 64'd0);
        check_eq("t1_flags", 64'({acerto, repetido}), 64'd0);
        @(negedge clk);
        check_eq("t1_pulse_end", 64'(resultado_valido), 64'd0);
        check_eq("t1_busy_clr", 64'(tiro_ocupado), 64'd0);
        check_eq("t1_row", mem1[3], 64'h0000_0000_0000_8000);

        // 2: ship on P2 row 0, column 0; P1 row 0 must stay untouched
        preload(1'b1, 5'd0, 64'hDEAD_BEEF_1234_5671);
        preload(1'b0, 5'd0, 64'h0123_4567_89AB_CDEF);
        run_shot(1'b1, 5'd0, 5'd0, 0, lat, wr1, wr2);
        check_eq("t2_lat", 64'(lat), 64'd7);
        check_eq("t2_wr1", 64'(wr1), 64'd0);
        check_eq("t2_wr2", 64'(wr2), 64'd1);
        check_eq("t2_flags", 64'({acerto, repetido}), 64'b10);
        @(negedge clk);
        check_eq("t2_row", mem2[0], 64'hDEAD_BEEF_1234_5673);
        check_eq("t2_other", mem1[0], 64'h0123_4567_89AB_CDEF);

        // 3: cell already hit, top column
        preload(1'b0, 5'd5, 64'hC000_0000_0000_00FF);
        run_shot(1'b0, 5'd5, 5'd31, 0, lat, wr1, wr2);
        check_eq("t3_lat", 64'(lat), 64'd6);
        check_eq("t3_wr", 64'(wr1 + wr2), 64'd0);
        check_eq("t3_flags", 64'({acerto, repetido}), 64'b01);
        @(negedge clk);
        check_eq("t3_row", mem1[5], 64'hC000_0000_0000_00FF);

        // 4: validator holds the bus for 5 cycles
        run_shot(1'b1, 5'd10, 5'd2, 5, lat, wr1, wr2);
        check_eq("t4_lat", 64'(lat), 64'd12);
        check_eq("t4_wr2", 64'(wr2), 64'd1);
        @(negedge clk);
        check_eq("t4_row", mem2[10], 64'h0000_0000_0000_0020);

        // 5: reset asserted in the WRITE cycle
        preload(1'b0, 5'd7, 64'd0);
        @(negedge clk);
        tiro_jogador = 1'b0;
        tiro_linha   = 5'd7;
        tiro_coluna  = 5'd0;
        tiro_valido  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            tiro_valido = 1'b0;
            n++;
        end while (!colisor_wrep1 && n < 40);
        check_eq("t5_in_write", 64'(colisor_wrep1), 64'd1);
        #1 resetGeral = 1'b0;
        #1;
        check_eq("t5_wren_async", 64'({colisor_wrep1, colisor_wrep2}), 64'd0);
        check_eq("t5_ready_async", 64'(readyColisor), 64'd0);
        check_eq("t5_busy_async", 64'(tiro_ocupado), 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= resultado_valido;
        end
        resetGeral = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen |= resultado_valido;
        end
        check_eq("t5_no_pulse", 64'(seen), 64'd0);
        check_eq("t5_no_write", mem1[7], 64'd0);
        run_shot(1'b0, 5'd7, 5'd0, 0, lat, wr1, wr2);
        check_eq("t5_recover_lat", 64'(lat), 64'd7);
        @(negedge clk);
        check_eq("t5_recover_row", mem1[7], 64'h0000_0000_0000_0002);

`ifdef COLISOR_PLACAR_EN
        // 6: two hits on P2 reach SHIP_CELLS=2
        preload(1'b1, 5'd20, 64'h0000_0000_0000_0005);
        run_shot(1'b1, 5'd20, 5'd0, 0, lat, wr1, wr2);
        check_eq("t6_p2_one", 64'(pontos_p2), 64'd1);
        check_eq("t6_fim_early", 64'(fim_jogo), 64'd0);
        run_shot(1'b1, 5'd20, 5'd1, 0, lat, wr1, wr2);
        check_eq("t6_p2_two", 64'(pontos_p2), 64'd2);
        check_eq("t6_fim", 64'(fim_jogo), 64'd1);
        run_shot(1'b1, 5'd20, 5'd0, 0, lat, wr1, wr2);
        check_eq("t6_rep", 64'(repetido), 64'd1);
        check_eq("t6_p2_hold", 64'(pontos_p2), 64'd2);
        check_eq("t6_p1", 64'(pontos_p1), 64'd0);
        check_eq("t6_fim_sticky", 64'(fim_jogo), 64'd1);
        @(negedge clk);
        check_eq("t6_row", mem2[20], 64'h0000_0000_0000_000F);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
